// File: rtl/serial_twos_comp_deser.sv
// serial_twos_comp_deser
// Receive side of the serial LSB-first two's-complement negation link.
// Each framed word is re-negated bit-serially (copy bits until the first 1,
// invert the rest) and collected into a parallel word. Because negation is
// its own inverse, this recovers the word the transmitter started from.
// Flags the most-negative-value case and words aborted by an early start.

module serial_twos_comp_deser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             in_start,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_ovf,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COPY   = 2'd1,
    INVERT = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_nxt_s;
  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] shreg_nxt_s;
  logic             low_zero_r;
  logic             low_zero_nxt_s;
  logic             accept_s;
  logic             start_s;
  logic             final_s;
  logic             decoded_s;
  logic             ovf_s;

  logic [WIDTH-1:0] out_data_r;
  logic             out_valid_r;
  logic             out_ovf_r;
  logic             frame_err_r;

  // Next-state, bit decoding, shift and overflow tracking for each accepted bit
  always_comb begin
    accept_s       = 1'b0;
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    shreg_nxt_s    = shreg_r;
    low_zero_nxt_s = low_zero_r;

    // Idle bits without a start marker are not part of any word.
    case (state_r)
      IDLE:         accept_s = in_valid & in_start;
      COPY, INVERT: accept_s = in_valid;
      default: begin
        accept_s    = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase

    start_s = accept_s & in_start;
    final_s = accept_s & ~in_start & (cnt_r == LAST_IDX);

    // A start bit is always bit 0 of a fresh word, so it is never inverted.
    if ((state_r == INVERT) && !in_start) begin
      decoded_s = ~in_bit;
    end else begin
      decoded_s = in_bit;
    end

    // Low bits all zero and a final 1 means the word was the most-negative value.
    ovf_s = low_zero_r & in_bit;

    if (accept_s) begin
      shreg_nxt_s = {decoded_s, shreg_r[WIDTH-1:1]};
      if (start_s) begin
        cnt_nxt_s      = CW'(1);
        low_zero_nxt_s = ~in_bit;
        state_nxt_s    = in_bit ? INVERT : COPY;
      end else if (final_s) begin
        cnt_nxt_s      = '0;
        low_zero_nxt_s = low_zero_r;
        state_nxt_s    = IDLE;
      end else begin
        cnt_nxt_s      = cnt_r + CW'(1);
        low_zero_nxt_s = low_zero_r & ~in_bit;
        if ((state_r == COPY) && in_bit) begin
          state_nxt_s = INVERT;
        end else begin
          state_nxt_s = state_r;
        end
      end
    end else begin
      cnt_nxt_s      = cnt_r;
      shreg_nxt_s    = shreg_r;
      low_zero_nxt_s = low_zero_r;
    end
  end

  // Word-assembly state: FSM, bit count, shift register, low-zero tracker
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      shreg_r    <= '0;
      low_zero_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      shreg_r    <= shreg_nxt_s;
      low_zero_r <= low_zero_nxt_s;
    end
  end

  // Registered outputs: completed word, overflow flag and abort pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      out_ovf_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      out_valid_r <= final_s;
      out_ovf_r   <= final_s & ovf_s;
      frame_err_r <= start_s & (state_r != IDLE);
      if (final_s) begin
        out_data_r <= shreg_nxt_s;
      end else begin
        out_data_r <= out_data_r;
      end
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_ovf   = out_ovf_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_serial_twos_comp_deser.sv
// Bench for serial_twos_comp_deser (WIDTH=8): table of words plus hand-written
// multi-cycle sequences; expected words go into a queue when sent and are
// popped by a negedge monitor whenever out_valid is seen.

module tb_serial_twos_comp_deser;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_bit;
  logic         in_valid;
  logic         in_start;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ovf;
  logic         frame_err;

  typedef struct {
    logic [W-1:0] word;
    logic [W-1:0] exp_data;
    logic         exp_ovf;
  } vec_t;

  vec_t tbl[8];

  logic [W:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int cyc = 0;
  int monitor_on = 0;

  serial_twos_comp_deser #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_bit   (in_bit),
    .in_valid (in_valid),
    .in_start (in_start),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ovf  (out_ovf),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Scoreboard and invariant monitor
  always @(negedge clk) begin
    if (monitor_on != 0) begin
      check("valid_and_ferr_exclusive", {31'd0, out_valid & frame_err}, 32'd0);
      if (!out_valid) check("ovf_without_valid", {31'd0, out_ovf}, 32'd0);
      if (frame_err) n_ferr++;
      if (out_valid) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          check("out_data", {24'd0, out_data}, {24'd0, e[W-1:0]});
          check("out_ovf", {31'd0, out_ovf}, {31'd0, e[W]});
        end
      end
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_start = 1'b0;
    in_bit   = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Sends one word LSB-first; returns at the negedge after the final bit's edge.
  task automatic send_word(input logic [W-1:0] w, input int gap_max);
    for (int i = 0; i < W; i++) begin
      in_valid = 1'b1;
      in_bit   = w[i];
      in_start = (i == 0);
      @(negedge clk);
      in_valid = 1'b0;
      in_start = 1'b0;
      if (gap_max > 0 && i < W - 1) repeat ($urandom_range(gap_max, 1)) @(negedge clk);
    end
  endtask

  initial begin
    int v0;
    int f0;
    int t0;
    logic [W-1:0] tmp;

    tbl[0] = '{word: 8'hFB, exp_data: 8'h05, exp_ovf: 1'b0};
    tbl[1] = '{word: 8'h00, exp_data: 8'h00, exp_ovf: 1'b0};
    tbl[2] = '{word: 8'h80, exp_data: 8'h80, exp_ovf: 1'b1};
    tbl[3] = '{word: 8'h01, exp_data: 8'hFF, exp_ovf: 1'b0};
    tbl[4] = '{word: 8'h7F, exp_data: 8'h81, exp_ovf: 1'b0};
    tbl[5] = '{word: 8'hC8, exp_data: 8'h38, exp_ovf: 1'b0};
    tbl[6] = '{word: 8'h40, exp_data: 8'hC0, exp_ovf: 1'b0};
    tbl[7] = '{word: 8'h81, exp_data: 8'h7F, exp_ovf: 1'b0};

    rst = 1'b1;
    in_valid = 1'b0;
    in_start = 1'b0;
    in_bit = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_out_data", {24'd0, out_data}, 32'd0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_ovf", {31'd0, out_ovf}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    monitor_on = 1;
    idle(1);

    // Table of single contiguous words, with 1-cycle latency check
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back({tbl[k].exp_ovf, tbl[k].exp_data});
      send_word(tbl[k].word, 0);
      check("latency_out_valid", {31'd0, out_valid}, 32'd1);
      idle(1);
    end

    // Idle bits without start are ignored, then a word with stalls
    v0 = n_valid;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_bit = 1'b1;
      in_start = 1'b0;
      @(negedge clk);
    end
    idle(2);
    check("idle_bits_ignored", n_valid - v0, 32'd0);
    exp_q.push_back({1'b0, 8'h10});
    send_word(8'hF0, 3);
    check("gapped_latency", {31'd0, out_valid}, 32'd1);
    idle(3);
    check("gapped_one_pulse", n_valid - v0, 32'd1);

    // Early start aborts a partial word
    v0 = n_valid;
    f0 = n_ferr;
    tmp = 8'h55;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_bit = tmp[i];
      in_start = (i == 0);
      @(negedge clk);
    end
    exp_q.push_back({1'b0, 8'hFF});
    in_valid = 1'b1;
    in_bit = 1'b1;
    in_start = 1'b1;
    @(negedge clk);
    check("frame_err_pulse", {31'd0, frame_err}, 32'd1);
    tmp = 8'h01;
    for (int i = 1; i < W; i++) begin
      in_valid = 1'b1;
      in_bit = tmp[i];
      in_start = 1'b0;
      @(negedge clk);
    end
    idle(3);
    check("frame_err_count", n_ferr - f0, 32'd1);
    check("abort_valid_count", n_valid - v0, 32'd1);

    // Reset mid-word discards the partial word silently
    v0 = n_valid;
    f0 = n_ferr;
    tmp = 8'h0F;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_bit = tmp[i];
      in_start = (i == 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midreset_out_data", {24'd0, out_data}, 32'd0);
    check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    exp_q.push_back({1'b0, 8'h02});
    send_word(8'hFE, 0);
    idle(3);
    check("midreset_no_ferr", n_ferr - f0, 32'd0);
    check("midreset_valid_count", n_valid - v0, 32'd1);

    // Back-to-back words with no idle cycle
    v0 = n_valid;
    f0 = n_ferr;
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h81});
    send_word(8'hFF, 0);
    check("b2b_first_valid", {31'd0, out_valid}, 32'd1);
    t0 = cyc;
    send_word(8'h7F, 0);
    check("b2b_second_valid", {31'd0, out_valid}, 32'd1);
    check("b2b_spacing", cyc - t0, 32'd8);
    idle(3);
    check("b2b_valid_count", n_valid - v0, 32'd2);
    check("b2b_no_ferr", n_ferr - f0, 32'd0);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    monitor_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
